// File: rtl/cv32e41s_rvfi_pkg.sv
// cv32e41s_rvfi_pkg: RVFI trap/interrupt info types and the trace record carried by the trace FIFO.
package cv32e41s_rvfi_pkg;

    localparam int TRACE_DROP_CNT_W = 16;

    typedef struct packed {
        logic       trap;
        logic       exception;
        logic [5:0] exception_cause;
        logic       debug;
        logic [2:0] debug_cause;
        logic [1:0] cause_type;
        logic       clicptr;
    } rvfi_trap_t;

    typedef struct packed {
        logic        intr;
        logic        exception;
        logic        interrupt;
        logic [10:0] cause;
    } rvfi_intr_t;

    typedef enum logic {
        TRACE_REC  = 1'b0,
        TRACE_DROP = 1'b1
    } rvfi_trace_kind_e;

    typedef struct packed {
        rvfi_trace_kind_e              kind;
        logic [63:0]                   order;
        logic [31:0]                   pc_rdata;
        logic [31:0]                   insn;
        rvfi_trap_t                    trap;
        rvfi_intr_t                    intr;
        logic [4:0]                    rd_addr;
        logic [31:0]                   rd_wdata;
        logic [TRACE_DROP_CNT_W-1:0]   drop_cnt;
    } rvfi_trace_rec_t;

endpackage

// File: rtl/cv32e41s_rvfi_trace_ram.sv
// cv32e41s_rvfi_trace_ram: trace record storage, one write port and a combinational read, data not reset.
module cv32e41s_rvfi_trace_ram
    import cv32e41s_rvfi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  rvfi_trace_rec_t          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output rvfi_trace_rec_t          rdata
);

    rvfi_trace_rec_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cv32e41s_rvfi_trace_fifo.sv
// cv32e41s_rvfi_trace_fifo: buffers RVFI retirements for a trace sink; never stalls the core,
// overflow drops are counted and reported by a single DROP marker once a slot frees.
module cv32e41s_rvfi_trace_fifo
    import cv32e41s_rvfi_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = TRACE_DROP_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trace_en_i,
    input  logic                     flush_i,
    input  logic                     rvfi_valid_i,
    input  logic [63:0]              rvfi_order_i,
    input  logic [31:0]              rvfi_pc_rdata_i,
    input  logic [31:0]              rvfi_insn_i,
    input  rvfi_trap_t               rvfi_trap_i,
    input  rvfi_intr_t               rvfi_intr_i,
    input  logic [4:0]               rvfi_rd_addr_i,
    input  logic [31:0]              rvfi_rd_wdata_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output rvfi_trace_rec_t          trace_rec_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] CAPTURE  = 1'b0;
    localparam logic [0:0] DROPPING = 1'b1;

    logic [AW:0]      wptr, rptr;
    logic [0:0]       state;
    logic [CNT_W-1:0] drop_cnt, drop_sat;
    logic             full, empty, cap, pop, we;
    rvfi_trace_rec_t  wrec, rrec;

    // full/empty come from registered pointers only, so a pop never frees a slot for a same-cycle push
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty    = wptr == rptr;
    assign cap      = rvfi_valid_i && trace_en_i;
    assign pop      = !flush_i && !empty && trace_ready_i;
    assign drop_sat = &drop_cnt ? drop_cnt : drop_cnt + CNT_W'(cap);
    assign we       = !flush_i && !full && (state == DROPPING || cap);

    always_comb begin
        wrec = '0;
        if (state == DROPPING) begin
            wrec.kind     = TRACE_DROP;
            wrec.drop_cnt = TRACE_DROP_CNT_W'(drop_sat);
        end else begin
            wrec.kind     = TRACE_REC;
            wrec.order    = rvfi_order_i;
            wrec.pc_rdata = rvfi_pc_rdata_i;
            wrec.insn     = rvfi_insn_i;
            wrec.trap     = rvfi_trap_i;
            wrec.intr     = rvfi_intr_i;
            wrec.rd_addr  = rvfi_rd_addr_i;
            wrec.rd_wdata = rvfi_rd_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            state      <= CAPTURE;
            drop_cnt   <= '0;
            overflow_o <= 1'b0;
        end else if (flush_i) begin
            wptr       <= '0;
            rptr       <= '0;
            state      <= CAPTURE;
            drop_cnt   <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (we) wptr <= wptr + (AW+1)'(1);
            if (pop) rptr <= rptr + (AW+1)'(1);
            if (state == CAPTURE) begin
                if (cap && full) begin
                    drop_cnt   <= CNT_W'(1);
                    overflow_o <= 1'b1;
                    state      <= DROPPING;
                end
            end else if (full) begin
                drop_cnt <= drop_sat;
            end else begin
                drop_cnt <= '0;
                state    <= CAPTURE;
            end
        end
    end

    cv32e41s_rvfi_trace_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr[AW-1:0]),
        .wdata (wrec),
        .raddr (rptr[AW-1:0]),
        .rdata (rrec)
    );

    assign trace_valid_o = !empty;
    assign trace_rec_o   = empty ? '0 : rrec;
    assign fifo_level_o  = wptr - rptr;

    a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n) we |-> !full);
    a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);
    a_level_bound:   assert property (@(posedge clk) disable iff (!rst_n) fifo_level_o <= (AW+1)'(DEPTH));

endmodule
